booth_r4_csa_mult: RTL
======================

# booth_r4_csa_mult

Sequential radix-4 Booth multiplier with carry-save accumulation, the parametrised successor of the single-bit full-adder cell in the Booth multiplier tree. It retires one Booth digit per cycle into a W-wide 3:2 compressor row and keeps the running product in redundant sum/carry form. A single carry-propagate add resolves the product at the end. Valid/ready handshakes on input and output let it sit between the operand source and result consumer of the Booth_Multi datapath.

## Interface
- W, 16: operand width; even, ≥4.
- SIGNED, 1: 1 = two's-complement operands; 0 = unsigned operands.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block accepts operands (high only in IDLE).
- a  in  W  multiplicand.
- b  in  W  multiplier.
- out_valid  out  1  product p is valid.
- out_ready  in  1  consumer takes p.
- p  out  2W  product, a*b mod 2^(2W).
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, RUN, RESOLVE, DONE.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, p=0; sum/carry/counter=0.
- IDLE to RUN on in_valid&in_ready.
  - Capture a, sign-extended to 2W when SIGNED=1, zero-extended otherwise.
  - Capture b, with implicit bit b[-1]=0; when SIGNED=0, b is zero-extended by 2 bits.
  - Clear sum, carry and digit counter i.
- Digit count ND = W/2 when SIGNED=1, W/2+1 when SIGNED=0.
- RUN, one digit per cycle:
  - Triplet {b[2i+1], b[2i], b[2i-1]} maps to digit 0, +1, +1, +2, -2, -1, -1, 0.
  - pp = |digit|·a << 2i, in 2W bits.
  - For a negative digit, pp = ~pp and a +1 is injected into carry bit 0. Bit 0 is always free because the carry vector is shifted left.
  - csa_row(sum, carry, pp) gives sum' = sum^carry^pp and carry' = maj(sum,carry,pp) << 1, truncated to 2W.
- RUN to RESOLVE when i = ND-1 after the update.
- RESOLVE: p <= sum + carry (mod 2^2W); out_valid <= 1; state to DONE.
- DONE: p and out_valid hold until out_ready=1, then out_valid <= 0 and state to IDLE.
- in_ready is low in RUN, RESOLVE and DONE. There is no same-cycle turnaround from DONE to accept.
- Arithmetic:
  - All intermediate vectors are 2W wide; overflow past bit 2W-1 is discarded.
  - The result is exact for every operand pair in the selected mode, including the extremes -2^(W-1)·-2^(W-1) and (2^W-1)².
- rst in any state aborts immediately: the partial product is discarded and no out_valid pulse occurs.
- in_valid while not IDLE is ignored; a and b need only be stable on the accept edge.

## Timing
- Accept edge = cycle 0.
- RUN updates occupy edges 1..ND; RESOLVE is at edge ND+1.
- out_valid is high from edge ND+1.
  - W=16, SIGNED=1: out_valid at edge 9.
  - W=16, SIGNED=0: out_valid at edge 10.
- With out_ready held high, back-to-back throughput is one product per ND+3 cycles.
- in_ready and busy are decoded directly from the state register, so they have no combinational path from the inputs.
- p is registered. out_valid does not depend combinationally on out_ready.
- Critical path: one 3:2 row plus the Booth mux in RUN; the 2W-bit CPA in RESOLVE.

## Structure
- Package booth_pkg:
  - state enum {IDLE, RUN, RESOLVE, DONE}.
  - Booth digit typedef (3-bit signed, -2..+2).
  - Function mapping the triplet to digit.
- Sub-module csa_row #(N): N-bit bitwise full-adder row (sum = x^y^z, cout = x&y | (x^y)&z). The carry shift is done in the parent.
- Top holds the FSM, digit counter ($clog2(ND) bits), operand registers, sum/carry registers, and the CPA.

## Test plan
- W=16, SIGNED=1, a=3, b=5 → p=0x0000000F, out_valid at edge 9 after accept.
- a=0x8000, b=0x8000 (signed) → p=0x40000000; a=0xFFFF, b=0x0001 → p=0xFFFFFFFF.
- SIGNED=0, a=0xFFFF, b=0xFFFF → p=0xFFFE0001, out_valid at edge 10.
- out_ready held low 5 cycles in DONE → p and out_valid stable, in_ready=0 throughout; after out_ready, in_ready=1 next cycle.
- rst asserted at RUN cycle 4 → next cycle state IDLE, out_valid=0, p=0; a fresh operation then completes correctly.
- 10k random operand pairs, both modes and W∈{4,16,32}, random in_valid/out_ready gaps → every p matches the golden model; no lost or duplicated results.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth carry-save multiplier: FSM states,
// Booth digit encoding and the multiplier-triplet recoder.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Signed Booth digit in -2..+2; bit 2 is the sign, bit 0 marks |d|=1, bit 1 marks |d|=2
    typedef logic signed [2:0] booth_digit_t;

    function automatic booth_digit_t booth_digit(input logic [2:0] trip);
        booth_digit_t d;
        case (trip)
            3'b001, 3'b010: d = booth_digit_t'(3'b001);
            3'b011:         d = booth_digit_t'(3'b010);
            3'b100:         d = booth_digit_t'(3'b110);
            3'b101, 3'b110: d = booth_digit_t'(3'b111);
            default:        d = booth_digit_t'(3'b000);
        endcase
        return d;
    endfunction

endpackage

// File: rtl/csa_row.sv
// N-bit row of independent full adders (3:2 compressor); the caller applies
// the carry weight shift.
module csa_row #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] z,
    output logic [N-1:0] sum,
    output logic [N-1:0] cout
);

    assign sum  = x ^ y ^ z;
    assign cout = (x & y) | ((x ^ y) & z);

endmodule

// File: rtl/booth_r4_csa_mult.sv
// Sequential radix-4 Booth multiplier: one digit per cycle into a carry-save
// accumulator, resolved by a single carry-propagate add before handoff.
module booth_r4_csa_mult
    import booth_pkg::*;
#(
    parameter int unsigned W      = 16,
    parameter bit          SIGNED = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  p,
    output logic            busy
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned BW = W + 3;
    localparam int unsigned ND = SIGNED ? (W / 2) : (W / 2 + 1);
    localparam int unsigned CW = $clog2(ND);

    state_t         state_q, state_d;
    logic [PW-1:0]  a_q, a_d;
    logic [BW-1:0]  b_q, b_d;
    logic [PW-1:0]  sum_q, sum_d;
    logic [PW-1:0]  carry_q, carry_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  p_q, p_d;
    logic           ov_q, ov_d;

    booth_digit_t   dig;
    logic           neg;
    logic [PW-1:0]  mag, pp, pp_x;
    logic [PW-1:0]  row_s, row_c;

    // Booth mux: select |d|*a, align to digit weight, invert for negative digits
    always_comb begin
        dig  = booth_digit(3'(b_q >> {cnt_q, 1'b0}));
        neg  = dig[2];
        mag  = dig[0] ? a_q : (dig[1] ? (a_q << 1) : '0);
        pp   = mag << {cnt_q, 1'b0};
        pp_x = neg ? ~pp : pp;
    end

    csa_row #(.N(PW)) u_row (
        .x    (sum_q),
        .y    (carry_q),
        .z    (pp_x),
        .sum  (row_s),
        .cout (row_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            ov_q    <= ov_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = {{W{SIGNED & a[W-1]}}, a};
                    b_d     = {{2{SIGNED & b[W-1]}}, b, 1'b0};
                    sum_d   = '0;
                    carry_d = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Carry bit 0 is vacated by the shift and carries the two's-complement +1
                sum_d   = row_s;
                carry_d = (row_c << 1) | PW'(neg);
                if (cnt_q == CW'(ND - 1)) begin
                    state_d = RESOLVE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESOLVE: begin
                p_d     = sum_q + carry_q;
                ov_d    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = ov_q;
    assign p         = p_q;

endmodule
